// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin packet arbiter feeding the 2:1 mux select.
// Grant locks for a whole packet; merged stream leaves through one output register.
module mux_sel_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             ptr;
    logic             ptr_nx;
    logic             sel_nx;
    logic             can_load;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;

    // Output slot is free when empty or being drained this cycle.
    assign can_load = ~out_valid | out_ready;
    assign xfer0    = in0_valid & in0_ready;
    assign xfer1    = in1_valid & in1_ready;
    assign xfer     = xfer0 | xfer1;
    assign ld_data  = xfer0 ? in0_data : in1_data;
    assign ld_last  = xfer0 ? in0_last : in1_last;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        sel_nx    = sel;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (in0_valid && (!in1_valid || !ptr)) begin
                    state_nx = GRANT0;
                    sel_nx   = 1'b1;
                end else if (in1_valid) begin
                    state_nx = GRANT1;
                    sel_nx   = 1'b0;
                end
            end
            GRANT0: begin
                in0_ready = can_load;
                if (in0_valid && can_load && in0_last) begin
                    state_nx = IDLE;
                    ptr_nx   = 1'b1;
                end
            end
            GRANT1: begin
                in1_ready = can_load;
                if (in1_valid && can_load && in1_last) begin
                    state_nx = IDLE;
                    ptr_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            sel   <= 1'b1;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= ld_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
